// File: rtl/operand_fetch_stage_if.sv
// Handshake bundle between the fetch stage, its instruction source and the execute stage.
interface operand_fetch_stage_if #(
    parameter int unsigned AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_op_a;
    logic [31:0]   out_op_b;
    logic [31:0]   out_op_c;
    logic [31:0]   out_imm;
    logic [AW-1:0] out_wr;
    logic          out_wen;
    logic [1:0]    out_func;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_op_a, out_op_b, out_op_c,
               out_imm, out_wr, out_wen, out_func
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_op_a, out_op_b, out_op_c,
               out_imm, out_wr, out_wen, out_func
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives RF read addresses, bypasses same-cycle writeback,
// tracks pending destinations in a scoreboard and registers operands for execute.
module operand_fetch_stage #(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    operand_fetch_stage_if.slave     bus,
    output logic [$clog2(NREGS)-1:0] src_a_o,
    output logic [$clog2(NREGS)-1:0] src_b_o,
    output logic [$clog2(NREGS)-1:0] src_c_o,
    input  logic [31:0]              out_a_i,
    input  logic [31:0]              out_b_i,
    input  logic [31:0]              out_c_i,
    input  logic                     wb_en_i,
    input  logic [$clog2(NREGS)-1:0] wb_addr_i,
    input  logic [31:0]              wb_data_i,
    input  logic                     flush_i,
    output logic [STALL_CNT_W-1:0]   stall_cnt_o
);
    localparam int unsigned AW   = $clog2(NREGS);
    localparam int unsigned DW   = 32;
    localparam int unsigned IMMW = 10;

    typedef struct packed {
        logic            wen;
        logic            use_a;
        logic            use_b;
        logic            use_c;
        logic [1:0]      func;
        logic [3:0]      wr;
        logic [3:0]      src_a;
        logic [3:0]      src_b;
        logic [3:0]      src_c;
        logic [IMMW-1:0] imm;
    } instr_t;

    typedef struct packed {
        logic [DW-1:0] op_a;
        logic [DW-1:0] op_b;
        logic [DW-1:0] op_c;
        logic [DW-1:0] imm;
        logic [AW-1:0] wr;
        logic          wen;
        logic [1:0]    func;
    } out_t;

    instr_t                 ins;
    out_t                   out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [NREGS-1:0]       sb_q, sb_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] sb_eff;
    logic             hazard;
    logic             space;
    logic             in_ready;
    logic             accept;
    logic [DW-1:0]    byp_a, byp_b, byp_c;

    assign ins = instr_t'(bus.in_instr);

    assign src_a_o = AW'(ins.src_a);
    assign src_b_o = AW'(ins.src_b);
    assign src_c_o = AW'(ins.src_c);

    // A pending bit being retired by this cycle's writeback no longer blocks issue
    assign wb_mask = wb_en_i ? (NREGS'(1) << wb_addr_i) : '0;
    assign sb_eff  = sb_q & ~wb_mask;

    assign hazard = (ins.use_a && sb_eff[ins.src_a]) ||
                    (ins.use_b && sb_eff[ins.src_b]) ||
                    (ins.use_c && sb_eff[ins.src_c]) ||
                    (ins.wen   && sb_eff[ins.wr]);

    assign space    = !out_valid_q || bus.out_ready;
    assign in_ready = reset && space && !hazard && !flush_i;
    assign accept   = bus.in_valid && in_ready;

    assign byp_a = (ins.use_a && wb_en_i && (wb_addr_i == AW'(ins.src_a))) ? wb_data_i : out_a_i;
    assign byp_b = (ins.use_b && wb_en_i && (wb_addr_i == AW'(ins.src_b))) ? wb_data_i : out_b_i;
    assign byp_c = (ins.use_c && wb_en_i && (wb_addr_i == AW'(ins.src_c))) ? wb_data_i : out_c_i;

    // Next-state for output entry, scoreboard and stall counter
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sb_d        = sb_q;
        stall_d     = stall_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_d.op_a   = byp_a;
            out_d.op_b   = byp_b;
            out_d.op_c   = byp_c;
            out_d.imm    = {{(DW-IMMW){ins.imm[IMMW-1]}}, ins.imm};
            out_d.wr     = AW'(ins.wr);
            out_d.wen    = ins.wen;
            out_d.func   = ins.func;
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        // Later writes win, so a new reservation overrides a same-cycle clear
        if (wb_en_i) begin
            sb_d[wb_addr_i] = 1'b0;
        end
        if (flush_i && out_valid_q && out_q.wen) begin
            sb_d[out_q.wr] = 1'b0;
        end
        if (accept && ins.wen) begin
            sb_d[ins.wr] = 1'b1;
        end

        if (bus.in_valid && !in_ready && !(&stall_q)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sb_q        <= '0;
            stall_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sb_q        <= sb_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op_a  = out_q.op_a;
    assign bus.out_op_b  = out_q.op_b;
    assign bus.out_op_c  = out_q.op_c;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_wr    = out_q.wr;
    assign bus.out_wen   = out_q.wen;
    assign bus.out_func  = out_q.func;
    assign stall_cnt_o   = stall_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: a reference model predicts handshake,
// scoreboard, stall count and the registered operand entries.
module tb_operand_fetch_stage;
    logic        clk;
    logic        reset;
    logic [3:0]  src_a, src_b, src_c;
    logic [31:0] rf_a, rf_b, rf_c;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [15:0] stall_cnt;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .src_a_o    (src_a),
        .src_b_o    (src_b),
        .src_c_o    (src_c),
        .out_a_i    (rf_a),
        .out_b_i    (rf_b),
        .out_c_i    (rf_c),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .flush_i    (flush),
        .stall_cnt_o(stall_cnt)
    );

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] op_c;
        logic [31:0] imm;
        logic [3:0]  wr;
        logic        wen;
        logic [1:0]  func;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_ov;
    logic [15:0] m_sb;
    logic [15:0] m_stall;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic wen, input logic ua, input logic ub,
                                       input logic uc, input logic [1:0] func,
                                       input logic [3:0] wr, input logic [3:0] sa,
                                       input logic [3:0] sb, input logic [3:0] sc,
                                       input logic [9:0] imm);
        return {wen, ua, ub, uc, func, wr, sa, sb, sc, imm};
    endfunction

    function automatic logic busy(input logic [3:0] r);
        return m_sb[r] && !(wb_en && wb_addr == r);
    endfunction

    // One cycle: check DUT against model at negedge+1, advance model, move to next negedge
    task automatic tick();
        logic [31:0] ins;
        logic        wen, ua, ub, uc, hz, rdy, acc;
        logic [3:0]  wr, sa, sb, sc;
        logic [15:0] sbn;
        exp_t        e;
        #1;
        ins = bus.in_instr;
        wen = ins[31]; ua = ins[30]; ub = ins[29]; uc = ins[28];
        wr  = ins[25:22]; sa = ins[21:18]; sb = ins[17:14]; sc = ins[13:10];
        hz  = (ua && busy(sa)) || (ub && busy(sb)) || (uc && busy(sc)) || (wen && busy(wr));
        rdy = (!m_ov || bus.out_ready) && !hz && !flush;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("src_abc", 32'({src_a, src_b, src_c}), 32'({sa, sb, sc}));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("scoreboard", 32'(dut.sb_q), 32'(m_sb));
        if (m_ov && exp_q.size() != 0) begin
            e = exp_q[0];
            check("out_op_a", bus.out_op_a, e.op_a);
            check("out_op_b", bus.out_op_b, e.op_b);
            check("out_op_c", bus.out_op_c, e.op_c);
            check("out_imm", bus.out_imm, e.imm);
            check("out_ctl", 32'({bus.out_wr, bus.out_wen, bus.out_func}),
                  32'({e.wr, e.wen, e.func}));
        end
        acc = bus.in_valid && rdy;
        sbn = m_sb;
        if (wb_en) sbn[wb_addr] = 1'b0;
        if (flush && m_ov && exp_q.size() != 0 && exp_q[0].wen) sbn[exp_q[0].wr] = 1'b0;
        if (acc && wen) sbn[wr] = 1'b1;
        if (m_ov && (flush || bus.out_ready) && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
            e.op_a = (ua && wb_en && wb_addr == sa) ? wb_data : rf_a;
            e.op_b = (ub && wb_en && wb_addr == sb) ? wb_data : rf_b;
            e.op_c = (uc && wb_en && wb_addr == sc) ? wb_data : rf_c;
            e.imm  = {{22{ins[9]}}, ins[9:0]};
            e.wr   = wr;
            e.wen  = wen;
            e.func = ins[27:26];
            exp_q.push_back(e);
        end
        if (flush)                        m_ov = 1'b0;
        else if (acc)                     m_ov = 1'b1;
        else if (m_ov && bus.out_ready)   m_ov = 1'b0;
        if (bus.in_valid && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        m_sb = sbn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
        rf_a = '0; rf_b = '0; rf_c = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_ov = 1'b0; m_sb = '0; m_stall = '0;
        reset = 1'b0;
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_instr = mk(1, 1, 0, 0, 2'd0, 4'd1, 4'd0, 4'd0, 4'd0, 10'd0);
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_scoreboard", 32'(dut.sb_q), 32'd0);
        check("rst_out_op_a", bus.out_op_a, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();

        // Basic issue with two sources
        bus.in_valid = 1'b1;
        bus.in_instr = mk(1, 1, 1, 0, 2'd1, 4'd2, 4'd12, 4'd13, 4'd0, 10'd5);
        rf_a = 32'd11; rf_b = 32'd22; rf_c = 32'd33;
        tick();
        check("t1_op_a", bus.out_op_a, 32'd11);
        check("t1_op_b", bus.out_op_b, 32'd22);
        check("t1_sb2", 32'(dut.sb_q[2]), 32'd1);

        // RAW stall, then release through same-cycle writeback bypass
        bus.in_instr = mk(0, 1, 0, 0, 2'd0, 4'd0, 4'd2, 4'd0, 4'd0, 10'd0);
        rf_a = 32'd55;
        repeat (3) tick();
        check("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'd789;
        tick();
        wb_en = 1'b0;
        check("t2_bypass", bus.out_op_a, 32'd789);
        check("t2_sb2", 32'(dut.sb_q[2]), 32'd0);

        // Backpressure holds the entry, then an all-ones imm issues
        bus.out_ready = 1'b0;
        bus.in_instr  = mk(0, 0, 0, 0, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 10'h3FF);
        repeat (5) tick();
        check("t3_held_op_a", bus.out_op_a, 32'd789);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t3_imm", bus.out_imm, 32'hFFFF_FFFF);
        tick();

        // WAW: second writer of r4 waits, then issues alongside r4's writeback
        bus.in_valid = 1'b1;
        bus.in_instr = mk(1, 0, 0, 0, 2'd2, 4'd4, 4'd0, 4'd0, 4'd0, 10'd7);
        tick();
        repeat (2) tick();
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0; bus.in_valid = 1'b0;
        tick();
        check("t4_sb4_set_wins", 32'(dut.sb_q[4]), 32'd1);
        wb_en = 1'b1; wb_addr = 4'd4;
        tick();
        wb_en = 1'b0;

        // Flush kills the entry and its reservation
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(1, 0, 0, 0, 2'd1, 4'd6, 4'd0, 4'd0, 4'd0, 10'd9);
        tick();
        bus.in_instr = mk(0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 10'd1);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_sb6", 32'(dut.sb_q[6]), 32'd0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_instr  = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            wb_en   = ($urandom_range(0, 2) == 0);
            wb_addr = 4'($urandom_range(0, 15));
            wb_data = $urandom;
            flush   = ($urandom_range(0, 15) == 0);
            rf_a = $urandom; rf_b = $urandom; rf_c = $urandom;
            tick();
        end
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            wb_en = 1'b1; wb_addr = 4'(r);
            tick();
        end
        wb_en = 1'b0;

        // Asynchronous reset in the middle of a RAW stall
        bus.in_valid = 1'b1;
        bus.in_instr = mk(1, 0, 0, 0, 2'd0, 4'd9, 4'd0, 4'd0, 4'd0, 10'd3);
        tick();
        bus.in_instr = mk(0, 1, 0, 0, 2'd0, 4'd0, 4'd9, 4'd0, 4'd0, 10'd0);
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        check("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_scoreboard", 32'(dut.sb_q), 32'd0);
        check("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        check("t6_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        exp_q.delete();
        m_ov = 1'b0; m_sb = '0; m_stall = '0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 16-entry, 3-read/1-write register file.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and drives the register file read addresses (srcA/srcB/srcC).
- Captures the returned operands, with same-cycle writeback bypass, into a single output pipeline register for the execute stage.
- Tracks in-flight destination registers with a 16-bit scoreboard and stalls on RAW/WAW hazards.

Parameters:
- NREGS, 16, register count; address width is log2(NREGS) = 4.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept the instruction this cycle.
- in_instr  in  32  [31]=wen, [30]=useA, [29]=useB, [28]=useC, [27:26]=func, [25:22]=wr, [21:18]=srcA, [17:14]=srcB, [13:10]=srcC, [9:0]=imm.
- srcA/srcB/srcC  out  4  register-file read addresses; combinational copies of in_instr fields.
- outA/outB/outC  in  32  register-file read data (combinational read).
- wb_en  in  1  writeback write-enable, same signal as register-file regWrite.
- wb_addr  in  4  writeback register, same as register-file wr.
- wb_data  in  32  writeback data, same as register-file writeData.
- flush  in  1  kill the output entry and block acceptance this cycle.
- out_valid  out  1  output entry valid.
- out_ready  in  1  execute stage consumes the entry.
- out_opA/out_opB/out_opC  out  32  fetched operands.
- out_imm  out  32  sign-extended imm.
- out_wr  out  4  destination register.
- out_wen  out  1  destination write-enable.
- out_func  out  2  function passthrough.
- stall_cnt  out  STALL_CNT_W  cycles with in_valid=1 and in_ready=0; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0; all out_* data=0; scoreboard=0; stall_cnt=0. in_ready is 0 while reset is asserted.
- Bypass: for each used source X, opX = (wb_en && wb_addr==srcX) ? wb_data : outX. Unused sources latch outX unmodified.
- Hazard (combinational):
  - Any used source with its scoreboard bit set, unless wb_en && wb_addr==that source this cycle.
  - OR wen=1 and the scoreboard bit for wr is set, unless it is being cleared by wb this cycle.
- Handshake:
  - space = !out_valid || out_ready.
  - in_ready = space && !hazard && !flush.
  - accept = in_valid && in_ready.
- Output register update, in priority order:
  - flush: out_valid<=0.
  - accept: load all out_* fields, out_valid<=1. Latency is 1 cycle from accept to out_valid.
  - out_ready && out_valid: out_valid<=0.
  - otherwise: hold. Data is stable while out_valid && !out_ready.
- Scoreboard update per cycle, applied in order:
  1. Clear bit wb_addr if wb_en.
  2. Clear bit out_wr if flush && out_valid && out_wen.
  3. Set bit in_instr wr if accept && wen.
  - Set wins over a same-cycle clear of the same bit.
  - WAW stall guarantees at most one pending writer per register.
- wb_en to a register with a clear scoreboard bit: no effect. This is legal, e.g. for external writes.
- stall_cnt: +1 per cycle with in_valid && !in_ready; holds at 2^STALL_CNT_W-1.
- Register 0 is an ordinary register; no hardwiring.
- Reset mid-operation: pending scoreboard bits and the output entry are dropped immediately.

Test Plan:
1. Release reset; instr wen=1 useA=1 useB=1 wr=2 srcA=12 srcB=13, with outA=11, outB=22 → next cycle out_valid=1, out_opA=11, out_opB=22, out_wr=2, scoreboard[2]=1.
2. RAW stall: next instr useA=1 srcA=2 while scoreboard[2]=1 and no wb → in_ready=0 and stall_cnt increments each cycle. Then wb_en=1, wb_addr=2, wb_data=789 → accepted that cycle, out_opA=789 (bypass), scoreboard[2]=0.
3. Backpressure: out_ready=0 with out_valid=1 → in_ready=0, out_* held constant for 5 cycles. out_ready=1 → next instr (imm=10'h3FF) is accepted, out_imm=32'hFFFFFFFF.
4. WAW: pending wr=4; new instr wen=1 wr=4 → stall. Same-cycle wb_addr=4 → accepted, scoreboard[4] ends at 1 (set wins).
5. Flush: out_valid=1, out_wen=1, out_wr=6; flush=1 → out_valid=0, scoreboard[6]=0, in_ready=0 that cycle even with in_valid=1.
6. Assert reset asynchronously mid-stall (between edges) → out_valid, scoreboard and stall_cnt go to 0 immediately without waiting for a clock edge.
